wm_tracker: RTL and testbench
=============================

WM_TRACKER -- requirements
Module: wm_tracker

Interface
REQ-001 Parameters: MUL_LAT, default 4, mul occupancy in cycles (1..31); DIV_LAT, default 16, div occupancy in cycles (1..31); FP_LAT, default 6, fp occupancy in cycles (1..31).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_l  in  1  synchronous, active-low reset.
REQ-004 imiss_set, imiss_clr, other_set, other_clr, stb_set, stb_clr, ld_set, ld_clr  in  4 each  per-thread set/clear pulses.
REQ-005 mul_req, div_req, fp_req  in  1 each  unit request valid; mul_tid, div_tid, fp_tid  in  2 each  requesting thread.
REQ-006 wm_imiss, wm_other, wm_stbwait, ldmiss  out  4 each  per-thread wait flags.
REQ-007 mul_wait, div_wait, fp_wait  out  4 each  threads queued on a busy unit.
REQ-008 mul_busy_e, div_busy_e, fp_busy_e  out  4 each  one-hot owner of each unit, zero when idle.
REQ-009 snap_valid  out  1; snap_data  out  40; snap_ready  in  1  change-record stream.
REQ-010 snap_ovf  out  1  sticky: at least one record dropped.

Function
REQ-011 All outputs are registered.
REQ-012 Simple flags (imiss, other, stbwait, ldmiss): per bit, set pulse -> 1 next cycle; clr pulse -> 0 next cycle; set and clr together -> set wins; neither -> hold.
REQ-013 Each unit (mul, div, fp) is an independent engine with states IDLE and BUSY, a 5-bit down-counter, a 4-bit owner vector, and a 4-bit wait vector.
REQ-014 Candidate set each cycle = wait vector OR one-hot(tid) if req; a request from a thread that is already owner or waiting is ignored.
REQ-015 Unit free this edge = IDLE, or BUSY with counter == 1.
REQ-016 If free and candidate set is non-empty, the lowest-numbered candidate is granted:
 - owner <= one-hot(grant);
 - its wait bit clears;
 - counter <= LAT;
 - state <= BUSY.
REQ-017 If free and candidate set is empty: state <= IDLE, owner <= 0.
REQ-018 If not free: counter decrements; non-granted candidates are added to the wait vector.
REQ-019 Ungranted candidates at a grant edge remain in or enter the wait vector.
REQ-020 Owner is therefore nonzero for exactly LAT cycles per grant; back-to-back grants have no idle gap.
REQ-021 Request on IDLE unit: busy_e bit set on the following cycle, wait bit never set.
REQ-022 Packed vector, MSB first: {wm_imiss, wm_other, wm_stbwait, mul_wait, div_wait, fp_wait, mul_busy_e, div_busy_e, fp_busy_e, ldmiss}.
REQ-023 Each cycle the packed output vector differs from its value on the previous cycle, that vector is pushed into a 4-entry FIFO.
REQ-024 FIFO head drives snap_data; snap_valid = not empty; pop when snap_valid & snap_ready.
REQ-025 FIFO full with no pop: the push is dropped and snap_ovf <= 1.
REQ-026 FIFO full with pop in the same cycle: the push is accepted.
REQ-027 FIFO empty with push in a cycle: snap_valid rises the next cycle.
REQ-028 Pointers wrap modulo 4; occupancy is 0..4.

Reset
REQ-029 rst_l low at a posedge: all flags, owners, wait vectors, counters, FIFO pointers, and snap_ovf go to 0; all units go to IDLE; snap_valid is 0.
REQ-030 Reset overrides any concurrent set, request, or pop.
REQ-031 The previous-vector register resets to 0, so the first nonzero vector after reset is recorded.
REQ-032 Reset mid-operation discards in-flight grants and records with no completion.

Verification
REQ-033 imiss_set=4'b0010 and imiss_clr=4'b0010 same cycle -> wm_imiss=4'b0010; one snap record 0x2000000000.
REQ-034 mul_req tid=1 on idle unit (MUL_LAT=4) -> mul_busy_e=4'b0010 for exactly 4 cycles, then 0; mul_wait stays 0.
REQ-035 div busy by tid0; tid3 then tid2 request -> div_wait=4'b1100; at completion div_busy_e=4'b0100, div_wait=4'b1000; after DIV_LAT more cycles div_busy_e=4'b1000.
REQ-036 snap_ready=0 and 6 consecutive distinct vector changes -> 4 records retained, snap_ovf=1; raise snap_ready -> oldest-first delivery, one per cycle.
REQ-037 rst_l low during fp BUSY with 2 waiters and 3 FIFO entries -> next cycle all outputs 0, snap_valid=0, snap_ovf=0.
REQ-038 Full FIFO, snap_ready=1, new change same cycle -> record accepted, snap_ovf stays 0.

Source files
------------

// File: rtl/wm_tracker_if.sv
// Change-record stream between wm_tracker and its consumer.
// The tracker drives valid/data/overflow; the consumer drives ready.
interface wm_tracker_if;
  logic        snap_valid;
  logic [39:0] snap_data;
  logic        snap_ready;
  logic        snap_ovf;

  modport master (
    output snap_valid,
    output snap_data,
    output snap_ovf,
    input  snap_ready
  );

  modport slave (
    input  snap_valid,
    input  snap_data,
    input  snap_ovf,
    output snap_ready
  );
endinterface

// File: rtl/wm_tracker.sv
// Per-thread wait-mask tracker.
// - Four simple set/clear flag vectors (set wins over clear).
// - Three execution units (mul, div, fp), each granting its lowest-numbered
//   candidate thread for a fixed occupancy, queueing the others.
// - Every change of the packed status vector is recorded into a 4-deep FIFO
//   exposed as a valid/ready stream, with a sticky overflow flag.
module wm_tracker #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int FP_LAT  = 6
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] imiss_set,
  input  logic [3:0] imiss_clr,
  input  logic [3:0] other_set,
  input  logic [3:0] other_clr,
  input  logic [3:0] stb_set,
  input  logic [3:0] stb_clr,
  input  logic [3:0] ld_set,
  input  logic [3:0] ld_clr,
  input  logic       mul_req,
  input  logic       div_req,
  input  logic       fp_req,
  input  logic [1:0] mul_tid,
  input  logic [1:0] div_tid,
  input  logic [1:0] fp_tid,
  output logic [3:0] wm_imiss,
  output logic [3:0] wm_other,
  output logic [3:0] wm_stbwait,
  output logic [3:0] ldmiss,
  output logic [3:0] mul_wait,
  output logic [3:0] div_wait,
  output logic [3:0] fp_wait,
  output logic [3:0] mul_busy_e,
  output logic [3:0] div_busy_e,
  output logic [3:0] fp_busy_e,
  wm_tracker_if.master snap
);

  typedef enum logic [0:0] {
    UNIT_IDLE = 1'b0,
    UNIT_BUSY = 1'b1
  } unit_state_t;

  // Unit index 0 = mul, 1 = div, 2 = fp.
  localparam logic [2:0][4:0] UNIT_LAT = {5'(FP_LAT), 5'(DIV_LAT), 5'(MUL_LAT)};

  function automatic logic [3:0] flag_next(input logic [3:0] cur,
                                           input logic [3:0] set,
                                           input logic [3:0] clr);
    return set | (cur & ~clr);
  endfunction

  function automatic logic [3:0] tid_onehot(input logic req, input logic [1:0] tid);
    logic [3:0] v;
    if (req) begin
      v = 4'b0001 << tid;
    end else begin
      v = 4'b0000;
    end
    return v;
  endfunction

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  // ---------------------------------------------------------------------
  // Simple flags
  // ---------------------------------------------------------------------

  // Set/clear flag registers; set has priority when both pulse together.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wm_imiss   <= 4'b0000;
      wm_other   <= 4'b0000;
      wm_stbwait <= 4'b0000;
      ldmiss     <= 4'b0000;
    end else begin
      wm_imiss   <= flag_next(wm_imiss, imiss_set, imiss_clr);
      wm_other   <= flag_next(wm_other, other_set, other_clr);
      wm_stbwait <= flag_next(wm_stbwait, stb_set, stb_clr);
      ldmiss     <= flag_next(ldmiss, ld_set, ld_clr);
    end
  end

  // ---------------------------------------------------------------------
  // Execution-unit engines
  // ---------------------------------------------------------------------
  logic [2:0]      unit_req_s;
  logic [2:0][1:0] unit_tid_s;
  logic [2:0][3:0] owner_a_s;
  logic [2:0][3:0] wait_a_s;

  assign unit_req_s = {fp_req, div_req, mul_req};
  assign unit_tid_s = {fp_tid, div_tid, mul_tid};

  for (genvar u = 0; u < 3; u++) begin : g_unit
    unit_state_t state_r;
    unit_state_t state_s;
    logic [4:0]  cnt_r;
    logic [4:0]  cnt_s;
    logic [3:0]  owner_r;
    logic [3:0]  owner_s;
    logic [3:0]  wait_r;
    logic [3:0]  wait_s;
    logic [3:0]  cand_s;
    logic [3:0]  grant_s;
    logic        free_s;

    // Next-state: grant lowest candidate when free, else count down and queue.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      owner_s = owner_r;
      wait_s  = wait_r;
      // A request from the current owner adds nothing; one from a waiter is already in wait_r.
      cand_s  = wait_r | (tid_onehot(unit_req_s[u], unit_tid_s[u]) & ~owner_r);
      grant_s = lowest_one(cand_s);
      free_s  = 1'b1;
      case (state_r)
        UNIT_IDLE: free_s = 1'b1;
        UNIT_BUSY: free_s = (cnt_r == 5'd1);
        default:   free_s = 1'b1;
      endcase
      if (free_s) begin
        if (cand_s != 4'b0000) begin
          state_s = UNIT_BUSY;
          cnt_s   = UNIT_LAT[u];
          owner_s = grant_s;
          wait_s  = cand_s & ~grant_s;
        end else begin
          state_s = UNIT_IDLE;
          cnt_s   = 5'd0;
          owner_s = 4'b0000;
          wait_s  = 4'b0000;
        end
      end else begin
        cnt_s  = cnt_r - 5'd1;
        wait_s = cand_s;
      end
    end

    // Unit state, counter, owner and wait registers.
    always_ff @(posedge clk) begin
      if (!rst_l) begin
        state_r <= UNIT_IDLE;
        cnt_r   <= 5'd0;
        owner_r <= 4'b0000;
        wait_r  <= 4'b0000;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        owner_r <= owner_s;
        wait_r  <= wait_s;
      end
    end

    assign owner_a_s[u] = owner_r;
    assign wait_a_s[u]  = wait_r;
  end

  assign mul_busy_e = owner_a_s[0];
  assign div_busy_e = owner_a_s[1];
  assign fp_busy_e  = owner_a_s[2];
  assign mul_wait   = wait_a_s[0];
  assign div_wait   = wait_a_s[1];
  assign fp_wait    = wait_a_s[2];

  // ---------------------------------------------------------------------
  // Change recorder and 4-entry FIFO
  // ---------------------------------------------------------------------
  logic [39:0]      vec_s;
  logic [39:0]      prev_r;
  logic [3:0][39:0] mem_r;
  logic [1:0]       wptr_r;
  logic [1:0]       rptr_r;
  logic [2:0]       count_r;
  logic             valid_r;
  logic [39:0]      head_r;
  logic             ovf_r;

  logic             push_s;
  logic             pop_s;
  logic             push_ok_s;
  logic             drop_s;
  logic [1:0]       wptr_s;
  logic [1:0]       rptr_s;
  logic [2:0]       count_s;
  logic [39:0]      head_s;

  assign vec_s = {wm_imiss, wm_other, wm_stbwait, mul_wait, div_wait, fp_wait,
                  mul_busy_e, div_busy_e, fp_busy_e, ldmiss};

  // FIFO control: accept a push when not full or when a pop frees a slot.
  always_comb begin
    push_s    = (vec_s != prev_r);
    pop_s     = valid_r & snap.snap_ready;
    push_ok_s = push_s & ((count_r != 3'd4) | pop_s);
    drop_s    = push_s & (count_r == 3'd4) & ~pop_s;
    wptr_s    = wptr_r;
    rptr_s    = rptr_r;
    count_s   = count_r;
    if (push_ok_s) begin
      wptr_s = wptr_r + 2'd1;
    end else begin
      wptr_s = wptr_r;
    end
    if (pop_s) begin
      rptr_s = rptr_r + 2'd1;
    end else begin
      rptr_s = rptr_r;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_s = count_r + 3'd1;
      2'b01:   count_s = count_r - 3'd1;
      default: count_s = count_r;
    endcase
    // The new head is the record being written whenever it lands at the next read slot.
    if (push_ok_s && (wptr_r == rptr_s)) begin
      head_s = vec_s;
    end else begin
      head_s = mem_r[rptr_s];
    end
  end

  // FIFO storage, pointers, registered head/valid and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      prev_r  <= 40'h0;
      mem_r   <= {4{40'h0}};
      wptr_r  <= 2'd0;
      rptr_r  <= 2'd0;
      count_r <= 3'd0;
      valid_r <= 1'b0;
      head_r  <= 40'h0;
      ovf_r   <= 1'b0;
    end else begin
      prev_r <= vec_s;
      if (push_ok_s) begin
        mem_r[wptr_r] <= vec_s;
      end
      wptr_r  <= wptr_s;
      rptr_r  <= rptr_s;
      count_r <= count_s;
      valid_r <= (count_s != 3'd0);
      head_r  <= head_s;
      ovf_r   <= ovf_r | drop_s;
    end
  end

  assign snap.snap_valid = valid_r;
  assign snap.snap_data  = head_r;
  assign snap.snap_ovf   = ovf_r;

endmodule

// File: tb/tb_wm_tracker.sv
// Directed bench for wm_tracker: expected change records are queued by the
// stimulus and checked by an independent stream monitor; unit and flag
// outputs are compared directly against hand-computed constants.
module tb_wm_tracker;
  logic       clk;
  logic       rst_l;
  logic [3:0] imiss_set, imiss_clr, other_set, other_clr;
  logic [3:0] stb_set, stb_clr, ld_set, ld_clr;
  logic       mul_req, div_req, fp_req;
  logic [1:0] mul_tid, div_tid, fp_tid;
  logic [3:0] wm_imiss, wm_other, wm_stbwait, ldmiss;
  logic [3:0] mul_wait, div_wait, fp_wait;
  logic [3:0] mul_busy_e, div_busy_e, fp_busy_e;

  wm_tracker_if snap();

  wm_tracker #(.MUL_LAT(4), .DIV_LAT(16), .FP_LAT(6)) dut (
    .clk(clk), .rst_l(rst_l),
    .imiss_set(imiss_set), .imiss_clr(imiss_clr),
    .other_set(other_set), .other_clr(other_clr),
    .stb_set(stb_set), .stb_clr(stb_clr),
    .ld_set(ld_set), .ld_clr(ld_clr),
    .mul_req(mul_req), .div_req(div_req), .fp_req(fp_req),
    .mul_tid(mul_tid), .div_tid(div_tid), .fp_tid(fp_tid),
    .wm_imiss(wm_imiss), .wm_other(wm_other), .wm_stbwait(wm_stbwait), .ldmiss(ldmiss),
    .mul_wait(mul_wait), .div_wait(div_wait), .fp_wait(fp_wait),
    .mul_busy_e(mul_busy_e), .div_busy_e(div_busy_e), .fp_busy_e(fp_busy_e),
    .snap(snap)
  );

  logic [39:0] obs_vec;
  assign obs_vec = {wm_imiss, wm_other, wm_stbwait, mul_wait, div_wait, fp_wait,
                    mul_busy_e, div_busy_e, fp_busy_e, ldmiss};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [39:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    imiss_set = 4'b0; imiss_clr = 4'b0; other_set = 4'b0; other_clr = 4'b0;
    stb_set = 4'b0; stb_clr = 4'b0; ld_set = 4'b0; ld_clr = 4'b0;
    mul_req = 1'b0; div_req = 1'b0; fp_req = 1'b0;
    mul_tid = 2'd0; div_tid = 2'd0; fp_tid = 2'd0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || snap.snap_valid) && i < 80) begin
      @(posedge clk);
      #2;
      i++;
    end
    chk({name, "_left"}, 40'(exp_q.size()), 40'd0);
    chk({name, "_valid"}, {39'd0, snap.snap_valid}, 40'd0);
  endtask

  // Stream monitor: every accepted record is compared with the oldest expectation.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (rst_l && snap.snap_valid && snap.snap_ready) begin
        if (exp_q.size() == 0) begin
          chk("snap_unexpected", snap.snap_data, 40'hXXXXXXXXXX);
        end else begin
          e = exp_q.pop_front();
          chk("snap_record", snap.snap_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_l = 1'b0;
    snap.snap_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_vec", obs_vec, 40'h0);
    chk("rst_valid", {39'd0, snap.snap_valid}, 40'd0);
    chk("rst_ovf", {39'd0, snap.snap_ovf}, 40'd0);
    rst_l = 1'b1;
    tick();

    // Set and clear together: set wins, one record.
    exp_q.push_back(40'h2000000000);
    exp_q.push_back(40'h0000000000);
    imiss_set = 4'b0010; imiss_clr = 4'b0010;
    tick();
    clear_inputs();
    @(negedge clk);
    chk("imiss_set_wins", {36'd0, wm_imiss}, 40'h2);
    imiss_clr = 4'b0010;
    tick();
    clear_inputs();
    @(negedge clk);
    chk("imiss_clr", {36'd0, wm_imiss}, 40'h0);
    drain("t1");

    // Two flag groups set in one cycle, cleared in the next.
    exp_q.push_back(40'h0960000000);
    exp_q.push_back(40'h0000000000);
    other_set = 4'b1001; stb_set = 4'b0110;
    tick();
    clear_inputs();
    other_clr = 4'b1001; stb_clr = 4'b0110;
    tick();
    clear_inputs();
    @(negedge clk);
    chk("other_stb_clr", {32'd0, wm_other, wm_stbwait}, 40'h0);
    drain("t1b");

    // mul request on idle unit: owner for exactly MUL_LAT cycles, never waits.
    exp_q.push_back(40'h0000002000);
    exp_q.push_back(40'h0000000000);
    mul_req = 1'b1; mul_tid = 2'd1;
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mul_busy_on", {32'd0, mul_busy_e, mul_wait}, 40'h20);
    end
    @(negedge clk);
    chk("mul_busy_off", {32'd0, mul_busy_e, mul_wait}, 40'h00);
    drain("t2");

    // div queueing: owner tid0, tid3 then tid2 wait, tid0 re-request ignored.
    exp_q.push_back(40'h0000000100);
    exp_q.push_back(40'h0000800100);
    exp_q.push_back(40'h0000C00100);
    exp_q.push_back(40'h0000800400);
    exp_q.push_back(40'h0000000800);
    exp_q.push_back(40'h0000000000);
    div_req = 1'b1; div_tid = 2'd0;
    tick();
    div_tid = 2'd3;
    tick();
    div_tid = 2'd2;
    tick();
    div_tid = 2'd0;
    tick();
    clear_inputs();
    @(negedge clk);
    chk("div_wait_1100", {32'd0, div_busy_e, div_wait}, 40'h1C);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("div_last_cycle_tid0", {32'd0, div_busy_e, div_wait}, 40'h1C);
    @(posedge clk);
    @(negedge clk);
    chk("div_grant_tid2", {32'd0, div_busy_e, div_wait}, 40'h48);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("div_last_cycle_tid2", {32'd0, div_busy_e, div_wait}, 40'h48);
    @(posedge clk);
    @(negedge clk);
    chk("div_grant_tid3", {32'd0, div_busy_e, div_wait}, 40'h80);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("div_idle", {32'd0, div_busy_e, div_wait}, 40'h00);
    drain("t3");

    // Overflow: six changes with ready low keep the four oldest.
    snap.snap_ready = 1'b0;
    exp_q.push_back(40'h0000000001);
    exp_q.push_back(40'h0000000003);
    exp_q.push_back(40'h0000000007);
    exp_q.push_back(40'h000000000F);
    ld_set = 4'b0001; tick();
    ld_set = 4'b0010; tick();
    ld_set = 4'b0100; tick();
    ld_set = 4'b1000; tick();
    ld_set = 4'b0000; ld_clr = 4'b0001; tick();
    ld_clr = 4'b0010; tick();
    clear_inputs();
    tick();
    @(negedge clk);
    chk("ovf_set", {39'd0, snap.snap_ovf}, 40'd1);
    chk("ovf_head", snap.snap_data, 40'h0000000001);
    chk("ovf_ldmiss", {36'd0, ldmiss}, 40'hC);
    tick();
    snap.snap_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("ovf_drain_4cyc", {39'd0, snap.snap_valid}, 40'd0);
    chk("ovf_sticky", {39'd0, snap.snap_ovf}, 40'd1);
    drain("t4");

    // Reset mid-operation: fp busy with two waiters and three queued records.
    snap.snap_ready = 1'b0;
    fp_req = 1'b1; fp_tid = 2'd0; tick();
    fp_tid = 2'd1; tick();
    fp_tid = 2'd2; tick();
    clear_inputs();
    tick();
    @(negedge clk);
    chk("fp_owner_waiters", {32'd0, fp_busy_e, fp_wait}, 40'h16);
    chk("fp_fifo_head", snap.snap_data, 40'h000000001C);
    rst_l = 1'b0;
    ld_set = 4'b1111; fp_req = 1'b1; fp_tid = 2'd3;
    tick();
    clear_inputs();
    rst_l = 1'b1;
    @(negedge clk);
    chk("midrst_vec", obs_vec, 40'h0);
    chk("midrst_valid", {39'd0, snap.snap_valid}, 40'd0);
    chk("midrst_ovf", {39'd0, snap.snap_ovf}, 40'd0);
    chk("midrst_data", snap.snap_data, 40'h0);
    tick();
    tick();
    @(negedge clk);
    chk("midrst_quiet", {obs_vec[38:0], snap.snap_valid}, 40'h0);
    tick();
    snap.snap_ready = 1'b1;
    drain("t5");

    // Full FIFO with pop and push in the same cycle: accepted, no overflow.
    snap.snap_ready = 1'b0;
    exp_q.push_back(40'h0000000001);
    exp_q.push_back(40'h0000000003);
    exp_q.push_back(40'h0000000007);
    exp_q.push_back(40'h000000000F);
    exp_q.push_back(40'h000000000E);
    ld_set = 4'b0001; tick();
    ld_set = 4'b0010; tick();
    ld_set = 4'b0100; tick();
    ld_set = 4'b1000; tick();
    ld_set = 4'b0000; ld_clr = 4'b0001; tick();
    clear_inputs();
    snap.snap_ready = 1'b1;
    @(negedge clk);
    chk("full_valid", {39'd0, snap.snap_valid}, 40'd1);
    tick();
    @(negedge clk);
    chk("full_pop_push_ovf", {39'd0, snap.snap_ovf}, 40'd0);
    drain("t6");
    chk("final_ovf", {39'd0, snap.snap_ovf}, 40'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
